rgb_colour_sequencer: RTL

// - Parametrised driver for a common seven-colour RGB LED. Generates timed ON/OFF flash phases.
// - Steps through the seven colours, or flashes one selected colour, under a runtime mode input.
// - Sits between the board clock and the LED pins; successor to the single-channel fixed-period flasher.

---
 rtl/led_colour_pkg.sv | 33 +++
 rtl/rgb_colour_sequencer_if.sv | 21 ++
 rtl/phase_timer.sv | 22 ++
 rtl/rgb_colour_sequencer.sv | 105 ++++++++++
 4 files changed

// File: rtl/led_colour_pkg.sv
// Shared types and constants for the RGB colour sequencer: mode encodings,
// FSM states and the seven-entry colour table.
package led_colour_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CYCLE  = 2'b10,
    MODE_STEADY = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ON   = 2'b01,
    ST_OFF  = 2'b10
  } state_t;

  localparam int NUM_COLOURS = 7;

  // {R,G,B}: R, G, B, Y, C, M, W
  localparam logic [2:0] COLOUR_LUT [NUM_COLOURS] = '{
    3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111
  };

  function automatic logic [2:0] clamp_colour(input logic [2:0] sel);
    return (sel == 3'd7) ? 3'd6 : sel;
  endfunction

  function automatic logic [2:0] next_cycle_colour(input logic [2:0] idx);
    return (idx == 3'd6) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/rgb_colour_sequencer_if.sv
// Control and LED-drive signals of the colour sequencer; the controller side
// is the master, the sequencer is the slave.
interface rgb_colour_sequencer_if;
  logic       en;
  logic [1:0] mode;
  logic [2:0] colour_sel;
  logic [2:0] led_rgb;
  logic [2:0] colour_idx;
  logic       phase_on;
  logic       cycle_done;

  modport master (
    output en, mode, colour_sel,
    input  led_rgb, colour_idx, phase_on, cycle_done
  );

  modport slave (
    input  en, mode, colour_sel,
    output led_rgb, colour_idx, phase_on, cycle_done
  );
endinterface

// File: rtl/phase_timer.sv
// Phase length timer: counts up from zero after a clear and flags the last
// cycle of a phase of `limit` cycles.
module phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) count <= '0;
    else                 count <= count + CNT_W'(1);
  end

  assign done = (count == limit - CNT_W'(1));

endmodule

// File: rtl/rgb_colour_sequencer.sv
// Seven-colour RGB LED sequencer: timed ON/OFF flash phases, stepping through
// the colour table or flashing one selected colour.
//
// state | meaning
// IDLE  | stopped, outputs at reset values
// ON    | LED lit with the current colour for ON_TICKS cycles
// OFF   | LED dark for OFF_TICKS cycles
module rgb_colour_sequencer
  import led_colour_pkg::*;
#(
  parameter int ON_TICKS   = 4000,
  parameter int OFF_TICKS  = 2000,
  parameter int CNT_W      = 32,
  parameter int ACTIVE_LOW = 0
) (
  input logic             clk,
  input logic             rst_n,
  rgb_colour_sequencer_if.slave bus
);

  if (ON_TICKS < 1) begin : g_on_ticks_check
    $error("ON_TICKS must be >= 1");
  end

  localparam logic [2:0] POL = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  state_t           state;
  mode_t            mode_q;
  logic [2:0]       cidx;
  logic             wrap_q;
  logic [2:0]       led_q;
  logic [2:0]       idx_q;
  logic             on_q;
  logic             done_q;

  mode_t            mode_in;
  logic             run;
  logic             restart;
  logic             has_off;
  logic [2:0]       sel_c;
  logic [2:0]       next_idx;
  logic             t_clear;
  logic             t_done;
  logic [CNT_W-1:0] t_limit;

  assign mode_in  = mode_t'(bus.mode);
  assign run      = bus.en && (mode_in != MODE_OFF);
  assign restart  = (state != ST_IDLE) && (mode_in != mode_q);
  assign has_off  = (OFF_TICKS > 0) && (mode_in != MODE_STEADY);
  assign sel_c    = clamp_colour(bus.colour_sel);
  assign next_idx = (mode_in == MODE_BLINK) ? sel_c : next_cycle_colour(cidx);
  assign t_limit  = (state == ST_OFF) ? CNT_W'(OFF_TICKS) : CNT_W'(ON_TICKS);
  assign t_clear  = !run || (state == ST_IDLE) || restart || t_done;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (t_clear),
    .limit (t_limit),
    .done  (t_done)
  );

  // Output registers trail the FSM by one cycle, except on stop where they
  // return to their reset values immediately.
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      state  <= ST_IDLE;
      mode_q <= MODE_OFF;
      cidx   <= 3'd0;
      wrap_q <= 1'b0;
      led_q  <= POL;
      idx_q  <= 3'd0;
      on_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mode_q <= mode_in;
      led_q  <= (state == ST_ON) ? (COLOUR_LUT[cidx] ^ POL) : POL;
      idx_q  <= cidx;
      on_q   <= (state == ST_ON);
      done_q <= wrap_q;
      wrap_q <= 1'b0;
      if (state == ST_IDLE) begin
        state <= ST_ON;
        cidx  <= (mode_in == MODE_BLINK) ? sel_c : 3'd0;
      end else if (restart) begin
        state <= ST_ON;
        if (mode_in == MODE_BLINK) cidx <= sel_c;
      end else if (t_done) begin
        if (state == ST_ON && has_off) begin
          state <= ST_OFF;
        end else begin
          state  <= ST_ON;
          cidx   <= next_idx;
          wrap_q <= (mode_in != MODE_BLINK) && (cidx == 3'd6);
        end
      end
    end
  end

  assign bus.led_rgb    = led_q;
  assign bus.colour_idx = idx_q;
  assign bus.phase_on   = on_q;
  assign bus.cycle_done = done_q;

endmodule
